bit_stuff_param: RTL and testbench

//   Parametrised bit stuffer for the serial transmit path, sitting between the

---
 rtl/bit_stuff_param.sv | 136 +++++++++++++
 tb/tb_bit_stuff_param.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_stuff_param.sv
// Serial-path bit stuffer: passes a packet preamble untouched, then inserts ~RUN_BIT after
// every RUN_LEN consecutive RUN_BIT bits, with a mandatory trailing stuff bit when a packet ends on a full run.
module bit_stuff_param #(
  parameter int   RUN_LEN  = 6,
  parameter int   PASS_LEN = 16,
  parameter logic RUN_BIT  = 1'b1,
  parameter int   CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             bypass,
  input  logic             s_in,
  input  logic             in_valid,
  input  logic             endb,
  output logic             in_ready,
  output logic             s_out,
  output logic             out_valid,
  output logic             start_nrzi,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] stuff_cnt
);

  typedef enum logic [2:0] {IDLE, PASS, STUFF, INSERT, TAIL} state_t;

  state_t           state_q, state_d;
  logic [4:0]       run_q, run_d, pass_q, pass_d, run_nx;
  logic             byp_q, byp_d;
  logic             s_out_q, s_out_d;
  logic             out_valid_q, out_valid_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      run_q       <= '0;
      pass_q      <= '0;
      byp_q       <= 1'b0;
      s_out_q     <= 1'b0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      pass_q      <= pass_d;
      byp_q       <= byp_d;
      s_out_q     <= s_out_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
      cnt_q       <= cnt_d;
    end
  end

  assign acc = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    run_d       = run_q;
    pass_d      = pass_q;
    byp_d       = byp_q;
    s_out_d     = s_out_q;
    out_valid_d = 1'b0;
    done_d      = 1'b0;
    cnt_d       = cnt_q;
    run_nx      = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          run_d   = '0;
          pass_d  = '0;
          cnt_d   = '0;
          byp_d   = bypass;
          state_d = PASS;
        end
      end
      PASS: begin
        if (acc) begin
          s_out_d     = s_in;
          out_valid_d = 1'b1;
          pass_d      = pass_q + 5'd1;
          if (endb) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else if (pass_q == 5'(PASS_LEN - 1)) begin
            state_d = STUFF;
          end
        end
      end
      STUFF: begin
        if (acc) begin
          s_out_d     = s_in;
          out_valid_d = 1'b1;
          run_nx      = (s_in == RUN_BIT && !byp_q) ? run_q + 5'd1 : 5'd0;
          run_d       = run_nx;
          // A full run on the last bit still owes its stuff bit, so done moves to TAIL.
          if (run_nx == 5'(RUN_LEN)) begin
            state_d = endb ? TAIL : INSERT;
          end else if (endb) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      INSERT, TAIL: begin
        s_out_d     = ~RUN_BIT;
        out_valid_d = 1'b1;
        run_d       = '0;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        if (state_q == TAIL) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          state_d = STUFF;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // busy also covers the done cycle, when the FSM is already back in IDLE.
  always_comb begin
    in_ready   = (state_q == PASS) || (state_q == STUFF);
    start_nrzi = (state_q == IDLE) && start;
    busy       = (state_q != IDLE) || done_q;
  end

  assign s_out     = s_out_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;
  assign stuff_cnt = cnt_q;

endmodule

// File: tb/tb_bit_stuff_param.sv
// Bench for bit_stuff_param: directed table, multi-cycle corner sequences, and random
// packets checked against a stream-level stuffing model.
module tb_bit_stuff_param;
  localparam int   RUN_LEN  = 6;
  localparam int   PASS_LEN = 16;
  localparam logic RUN_BIT  = 1'b1;
  localparam int   CNT_W    = 8;

  logic clk, rst, start, bypass, s_in, in_valid, endb;
  logic in_ready, s_out, out_valid, start_nrzi, done, busy;
  logic [CNT_W-1:0] stuff_cnt;

  bit_stuff_param #(.RUN_LEN(RUN_LEN), .PASS_LEN(PASS_LEN), .RUN_BIT(RUN_BIT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .bypass(bypass), .s_in(s_in), .in_valid(in_valid),
    .endb(endb), .in_ready(in_ready), .s_out(s_out), .out_valid(out_valid),
    .start_nrzi(start_nrzi), .done(done), .busy(busy), .stuff_cnt(stuff_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         byp;
    logic [127:0] in_bits;
    int           in_len;
    int           gap_at;
    int           gap_len;
    logic         chk_gap;
    logic [127:0] exp_bits;
    int           exp_len;
    int           exp_stuff;
    int           exp_stall;
  } vec_t;

  int tests = 0, fails = 0, stalls = 0;

  // output stream capture, restarted on every accepted start
  logic [127:0] obits;
  int ocnt = 0, done_cnt = 0, done_idx = -1;
  always @(negedge clk) begin
    if (start_nrzi) begin
      ocnt <= 0; done_cnt <= 0; done_idx <= -1;
    end else begin
      if (out_valid) begin
        if (ocnt < 128) obits[ocnt] <= s_out;
        ocnt <= ocnt + 1;
      end
      if (done) begin
        done_cnt <= done_cnt + 1;
        done_idx <= out_valid ? ocnt : ocnt - 1;
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [127:0] ones(input int from, input int cnt);
    logic [127:0] v = '0;
    for (int k = from; k < from + cnt; k++) v[k] = 1'b1;
    return v;
  endfunction

  // Reference: preamble copied verbatim, then a ~RUN_BIT follows every RUN_LEN-long run.
  function automatic void model(input logic [127:0] b, input int n, input logic byp,
                                output logic [127:0] o, output int olen, output int ns,
                                output int nstall);
    int run = 0;
    o = '0; olen = 0; ns = 0; nstall = 0;
    for (int i = 0; i < n; i++) begin
      o[olen] = b[i]; olen++;
      if (!byp && i >= PASS_LEN) begin
        run = (b[i] == RUN_BIT) ? run + 1 : 0;
        if (run == RUN_LEN) begin
          o[olen] = ~RUN_BIT; olen++; ns++; run = 0;
          if (i != n - 1) nstall++;
        end
      end
    end
  endfunction

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic start_pkt(input logic byp);
    start = 1'b1; bypass = byp;
    @(negedge clk);
    chk("start_nrzi", start_nrzi, 1);
    cyc();
    start = 1'b0; bypass = 1'b0;
  endtask

  task automatic send_bit(input logic b, input logic e);
    int k;
    in_valid = 1'b1; s_in = b; endb = e;
    for (k = 0; k < 10; k++) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      cyc();
    end
    if (k == 10) chk("accept_timeout", 0, 1);
    else cyc();
    in_valid = 1'b0; endb = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done) break;
    end
    if (k == 20) chk("done_timeout", 0, 1);
    cyc();
    @(negedge clk);
    chk("busy_after_done", busy, 0);
  endtask

  task automatic run_pkt(input vec_t v, input string tag);
    int bad = -1;
    stalls = 0;
    start_pkt(v.byp);
    for (int i = 0; i < v.in_len; i++) begin
      if (i == v.gap_at) begin
        in_valid = 1'b0;
        for (int g = 0; g < v.gap_len; g++) begin
          @(negedge clk);
          if (v.chk_gap && g == 1) chk({tag, "_gap_ov"}, out_valid, 0);
          cyc();
        end
      end
      send_bit(v.in_bits[i], i == v.in_len - 1);
    end
    wait_done();
    for (int j = 0; j < v.exp_len; j++)
      if (obits[j] !== v.exp_bits[j] && bad < 0) bad = j;
    chk({tag, "_len"}, ocnt, v.exp_len);
    chk({tag, "_bits_first_bad"}, bad, -1);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_done_idx"}, done_idx, v.exp_len - 1);
    chk({tag, "_stuff_cnt"}, int'(stuff_cnt), v.exp_stuff);
    chk({tag, "_stalls"}, stalls, v.exp_stall);
    cyc();
  endtask

  task automatic chk_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_s_out"}, s_out, 0);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_start_nrzi"}, start_nrzi, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_stuff_cnt"}, int'(stuff_cnt), 0);
  endtask

  vec_t tbl[8];
  vec_t rv;

  initial begin
    rst = 1'b1; start = 1'b0; bypass = 1'b0; s_in = 1'b0; in_valid = 1'b0; endb = 1'b0;
    tbl[0] = '{1'b0, ones(0,22), 23, -1, 0, 1'b0, ones(0,22), 24, 1, 1};
    tbl[1] = '{1'b0, ones(0,21) | ones(22,5), 28, -1, 0, 1'b0, ones(0,21) | ones(22,5), 28, 0, 0};
    tbl[2] = '{1'b0, ones(0,22), 22, -1, 0, 1'b0, ones(0,22), 23, 1, 0};
    tbl[3] = '{1'b1, ones(0,28), 28, -1, 0, 1'b0, ones(0,28), 28, 0, 0};
    tbl[4] = '{1'b0, ones(0,22), 23, 19, 2, 1'b1, ones(0,22), 24, 1, 1};
    tbl[5] = '{1'b0, ones(0,1) | ones(2,2), 5, -1, 0, 1'b0, ones(0,1) | ones(2,2), 5, 0, 0};
    tbl[6] = '{1'b0, ones(0,16), 16, -1, 0, 1'b0, ones(0,16), 16, 0, 0};
    tbl[7] = '{1'b0, ones(0,28), 28, -1, 0, 1'b0, ones(0,22) | ones(23,6), 30, 2, 1};

    chk_idle_outputs("reset");
    cyc();
    rst = 1'b0;
    cyc();

    for (int t = 0; t < 8; t++) run_pkt(tbl[t], $sformatf("vec%0d", t));

    // start outside IDLE must not restart the packet
    start_pkt(1'b0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
    start = 1'b1;
    send_bit(1'b0, 1'b1);
    start = 1'b0;
    @(negedge clk);
    chk("ign_start_done", done, 1);
    chk("ign_start_len", ocnt + (out_valid ? 1 : 0), 4);
    cyc(); cyc();

    // abort mid-packet by reset
    start_pkt(1'b0);
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'b0);
    rst = 1'b1;
    chk_idle_outputs("abort");
    cyc();
    rst = 1'b0;
    repeat (3) cyc();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_idle_busy", busy, 0);
    run_pkt(tbl[0], "post_abort");

    // stuff counter saturation: 260 stuffs on an 8-bit counter
    start_pkt(1'b0);
    for (int i = 0; i < PASS_LEN + RUN_LEN * 260; i++) send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b1);
    wait_done();
    chk("sat_stuff_cnt", int'(stuff_cnt), 255);
    chk("sat_len", ocnt, PASS_LEN + RUN_LEN * 260 + 260 + 1);
    chk("sat_done_cnt", done_cnt, 1);
    cyc();

    for (int r = 0; r < 40; r++) begin
      rv.byp = ($urandom_range(0, 9) == 0);
      rv.in_len = $urandom_range(1, 100);
      rv.in_bits = '0;
      for (int i = 0; i < rv.in_len; i++) rv.in_bits[i] = ($urandom_range(0, 4) != 0);
      rv.gap_at = $urandom_range(0, rv.in_len - 1);
      rv.gap_len = $urandom_range(0, 3);
      rv.chk_gap = 1'b0;
      model(rv.in_bits, rv.in_len, rv.byp, rv.exp_bits, rv.exp_len, rv.exp_stuff, rv.exp_stall);
      run_pkt(rv, $sformatf("rnd%0d", r));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
